// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: CPU-side load/store initiator for a word-organised memory.
// Sub-word stores are done as read-modify-write because the memory only
// accepts whole-word writes. Memory controls are decoded from registered
// state only, so there is no combinational path from req_* to mem_*.
// Optional build macro: MEM_ACCESS_CTRL_BOUND_CHECK_EN rejects any request
// whose address bits above the memory word index are non-zero.
module mem_access_ctrl #(
  parameter int unsigned RAM_SIZE_BIT = 8,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

`ifdef MEM_ACCESS_CTRL_BOUND_CHECK_EN
  localparam bit BOUND_EN = 1'b1;
`else
  localparam bit BOUND_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state_q, state_d;
  logic              write_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q;

  logic              accept;
  logic              upper_nz;
  logic              req_err;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       load_ext;
  logic [31:0]       merged;

  assign accept   = req_valid && (state_q == IDLE);
  assign upper_nz = |req_addr[ADDR_W-1:RAM_SIZE_BIT+2];
  assign req_err  = (req_size == 2'b11)
                 || ((req_size == 2'b01) && req_addr[0])
                 || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                 || (BOUND_EN && upper_nz);

  // Lane selection and extension of the live memory word for loads
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = mem_rdata[7:0];
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{signed_q & lane_h[15]}}, lane_h};
      default: load_ext = mem_rdata;
    endcase
  end

  // Write word: store data replaces the addressed lane(s) of the captured word
  always_comb begin
    merged = word_q;
    case (size_q)
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    merged[7:0]   = wdata_q[7:0];
          2'd1:    merged[15:8]  = wdata_q[7:0];
          2'd2:    merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  // Next-state and response-data selection
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d = DONE;
            rdata_d = '0;
          end else if (req_write && (req_size == 2'b10)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (write_q) begin
          state_d = WR;
        end else begin
          state_d = DONE;
          rdata_d = load_ext;
        end
      end
      WR: begin
        state_d = DONE;
        rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request capture and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (accept) begin
        write_q  <= req_write;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= req_err;
      end
      if (state_q == RD) word_q <= mem_rdata;
    end
  end

  // Moore outputs
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
    rsp_err   = (state_q == DONE) && err_q;
    rsp_rdata = rdata_q;
    mem_read  = (state_q == RD);
    mem_write = (state_q == WR);
    mem_addr  = '0;
    mem_wdata = '0;
    if ((state_q == RD) || (state_q == WR)) mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    if (state_q == WR) mem_wdata = merged;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: word memory environment plus a byte-array
// reference model; directed plan steps followed by randomized traffic.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem  [0:255]  = '{default: '0};
  logic [7:0]  refm [0:1023] = '{default: '0};
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl #(.RAM_SIZE_BIT(8), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    int nb = nbytes(sz);
    int base = int'(a[9:0]);
    logic [31:0] v = '0;
    for (int i = 0; i < nb; i++) v = v | (32'(refm[base + i]) << (8 * i));
    if (sg && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ref_load(2'd2, 1'b0, {a[31:2], 2'b00});
  endfunction

  task automatic xact(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd);
    int unsigned n, lat, nrd, nwr;
    logic seen, err, got_err;
    logic [31:0] waddr, wdat, got_rd, exp_rd;
    int exp_lat;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    exp_rd = (err || w) ? 32'h0 : ref_load(sz, sg, a);
    exp_lat = err ? 1 : (!w ? 2 : (sz == 2'd2 ? 2 : 3));
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    chk("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = ~w; req_size = 2'($urandom);
    req_signed = ~sg; req_addr = $urandom; req_wdata = $urandom;
    seen = 1'b0; lat = 0; nrd = 0; nwr = 0;
    waddr = '0; wdat = '0; got_rd = '0; got_err = 1'b0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (mem_read) nrd++;
      if (mem_write) begin nwr++; waddr = mem_addr; wdat = mem_wdata; end
      if (rsp_valid) begin seen = 1'b1; lat = c; got_rd = rsp_rdata; got_err = rsp_err; end
    end
    chk("rsp_seen", {31'b0, seen}, 32'd1);
    chk("latency", lat, exp_lat);
    chk("rsp_err", {31'b0, got_err}, {31'b0, err});
    chk("rsp_rdata", got_rd, exp_rd);
    chk("mem_read_cycles", nrd, (err || (w && sz == 2'd2)) ? 0 : 1);
    chk("mem_write_cycles", nwr, (!err && w) ? 1 : 0);
    last_rdata = got_rd;
    if (w && !err) begin
      chk("mem_write_addr", waddr, {a[31:2], 2'b00});
      for (int i = 0; i < nbytes(sz); i++) refm[int'(a[9:0]) + i] = wd[8 * i +: 8];
      if (sz == 2'd2) chk("word_wdata", wdat, wd);
    end
    chk("mem_word", mem[a[9:2]], ref_word(a));
  endtask

  initial begin
    int unsigned acc2, pulses, p1, p2, mw, rv;
    logic [31:0] ra, rb, tmp;
    logic [1:0] sz;
    int unsigned r;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = '0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_ctl", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    // Word store then word load
    xact(1'b1, 2'd2, 1'b0, 32'h40, 32'h1234_5678);
    xact(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    chk("plan_word_load", last_rdata, 32'h1234_5678);

    // Byte RMW
    xact(1'b1, 2'd2, 1'b0, 32'h80, 32'hAABB_CCDD);
    xact(1'b1, 2'd0, 1'b0, 32'h82, 32'hFFFF_FF11);
    chk("plan_rmw_word", mem[32], 32'hAA11_CCDD);

    // Signed/unsigned sub-word loads
    xact(1'b0, 2'd0, 1'b1, 32'h80, 32'h0);
    chk("plan_sbyte", last_rdata, 32'hFFFF_FFDD);
    xact(1'b0, 2'd1, 1'b0, 32'h82, 32'h0);
    chk("plan_uhalf", last_rdata, 32'h0000_AA11);
    xact(1'b0, 2'd1, 1'b1, 32'h80, 32'h0);
    chk("plan_shalf", last_rdata, 32'hFFFF_CCDD);

    // Misaligned access
    xact(1'b0, 2'd2, 1'b0, 32'h42, 32'h0);
    xact(1'b1, 2'd1, 1'b0, 32'h41, 32'hBEEF);
    chk("plan_misaligned_mem", mem[16], 32'h1234_5678);

    // Reset during the RD cycle of a byte RMW
    xact(1'b1, 2'd2, 1'b0, 32'h84, 32'h5555_5555);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h84; req_wdata = 32'hEE;
    @(posedge clk);
    #1;
    req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("abort_in_rd", {31'b0, mem_read}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    mw = 0; rv = 0;
    for (int c = 0; c < 4; c++) begin
      if (mem_write) mw++;
      if (rsp_valid) rv++;
      @(negedge clk);
    end
    chk("abort_no_write", mw, 32'd0);
    chk("abort_no_rsp", rv, 32'd0);
    chk("abort_word", mem[33], 32'h5555_5555);

    // Back-to-back loads with req_valid held high
    ra = ref_load(2'd2, 1'b0, 32'h40);
    rb = ref_load(2'd2, 1'b0, 32'h80);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h40;
    @(posedge clk);
    #1;
    req_addr = 32'h80;
    acc2 = 0; pulses = 0; p1 = 0; p2 = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (acc2 != 0) req_valid = 1'b0;
      if (c == 1) chk("b2b_ready_rd", {31'b0, req_ready}, 32'd0);
      if (c == 2) chk("b2b_ready_done", {31'b0, req_ready}, 32'd0);
      if (req_valid && req_ready && acc2 == 0) acc2 = c;
      if (rsp_valid) begin
        pulses++;
        if (pulses == 1) begin p1 = c; chk("b2b_rdata_a", rsp_rdata, ra); end
        if (pulses == 2) begin p2 = c; chk("b2b_rdata_b", rsp_rdata, rb); end
      end
    end
    req_valid = 1'b0;
    chk("b2b_second_accept", acc2, 32'd3);
    chk("b2b_pulses", pulses, 32'd2);
    chk("b2b_pulse_cycles", {p1[15:0], p2[15:0]}, {16'd2, 16'd5});

    // Randomized traffic in a small aliased window
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 15);
      sz = (r == 15) ? 2'd3 : 2'(r % 3);
      tmp = $urandom;
      xact(1'($urandom), sz, 1'($urandom),
           (tmp & 32'hFFFF_FC00) | 32'($urandom_range(0, 63)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- CPU-side initiator for the word-organised instruction/data memory (combinational read, posedge-clock write, word index = Address[RAM_SIZE_BIT+1:2]).
- Accepts byte/halfword/word load and store requests through a valid/ready handshake, drives Address/Write_data/MemRead/MemWrite, and returns sign- or zero-extended load data.
- Sub-word stores are done as read-modify-write, because the memory only supports whole-word writes.
- Sits between the multi-cycle CPU datapath and the memory.

Parameters:
- RAM_SIZE_BIT, 8, log2 of memory depth in words; must match the memory instance.
- ADDR_W, 32, width of the request and memory address buses.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (error).
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- rsp_valid  out  1  one-cycle pulse: request complete.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or reserved-size request; qualified by rsp_valid.
- mem_addr  out  ADDR_W  memory Address, word-aligned (bits [1:0] = 0).
- mem_wdata  out  32  memory Write_data.
- mem_read  out  1  memory MemRead.
- mem_write  out  1  memory MemWrite.
- mem_rdata  in  32  memory Mem_data (combinational, same cycle).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset:
  - State goes to IDLE.
  - req_ready = 1; rsp_valid = 0; rsp_err = 0; rsp_rdata = 0.
  - mem_read = 0; mem_write = 0; mem_addr = 0; mem_wdata = 0.
- Memory controls are decoded from registered state only (Moore); no combinational path from req_* to mem_*.
- Request registers are loaded on the accept edge (req_valid && req_ready). Input changes after accept are ignored.
- States: IDLE, RD, WR, DONE.
- Transitions from IDLE on accept:
  - Error request -> DONE.
  - Load -> RD.
  - Word store -> WR.
  - Byte/halfword store -> RD.
- Other transitions:
  - RD -> DONE for a load; RD -> WR for a store.
  - WR -> DONE.
  - DONE -> IDLE.
  - No request is accepted in DONE, so there is one bubble between requests.
- Error conditions:
  - Halfword with addr[0] = 1.
  - Word with addr[1:0] != 0.
  - req_size = 11.
  - On error: no memory access; rsp_err = 1 and rsp_rdata = 0 in DONE.
- RD:
  - mem_read = 1; mem_addr = {addr[ADDR_W-1:2], 2'b00}.
  - mem_rdata is captured into a word register on the exiting edge.
- WR:
  - mem_write = 1; mem_addr = aligned address.
  - mem_wdata = req_wdata for a word store.
  - For a byte/halfword store, mem_wdata = captured word with the addressed lane(s) replaced and all other bytes preserved.
- Lane order is little-endian:
  - Byte lane k = bits [8k+7:8k], k = addr[1:0].
  - Halfword lane = addr[1] (0 -> [15:0], 1 -> [31:16]).
- Load extraction: select the lane, then sign- or zero-extend per req_signed. The result is registered and presented in DONE.
- Latency, counted in cycles from the accept edge to the rsp_valid cycle:
  - Load: 2.
  - Word store: 2.
  - Sub-word store: 3.
  - Error: 1.
- Outputs outside DONE: rsp_valid = 0, rsp_err = 0. rsp_rdata holds its last value.
- Reset mid-operation (in RD or WR): the next state is IDLE and mem_write deasserts. No partial write happens after the reset edge, and no rsp_valid is issued for the aborted request.
- Address bits above RAM_SIZE_BIT+1 pass through unchanged; the memory aliases them.

Optional Feature:
- Macro: MEM_ACCESS_CTRL_BOUND_CHECK_EN.
- When defined: any request with req_addr[ADDR_W-1:RAM_SIZE_BIT+2] != 0 is treated as an error. Path is IDLE -> DONE, rsp_err = 1, no memory access.
- When undefined: no bound check; upper address bits alias into the memory.

Test Plan:
- Word store then word load:
  - Store 0x12345678 to 0x40, then load word from 0x40.
  - Required: mem_write high for exactly 1 cycle with mem_addr = 0x40.
  - Required: rsp_rdata = 0x12345678 two cycles after accept; rsp_err = 0.
- Byte RMW:
  - Memory word at 0x80 = 0xAABBCCDD; store byte 0x11 to 0x82.
  - Required: sequence RD, WR, DONE; memory word becomes 0xAA11CCDD.
- Signed/unsigned sub-word load (word at 0x80 = 0xAA11CCDD):
  - Signed byte load from 0x80 -> 0xFFFFFFDD.
  - Unsigned halfword load from 0x82 -> 0x0000AA11.
  - Signed halfword load from 0x80 -> 0xFFFFCCDD.
- Misaligned access:
  - Word load from 0x42 -> rsp_valid and rsp_err = 1 one cycle after accept, rsp_rdata = 0, mem_read and mem_write never asserted.
  - Halfword store to 0x41 -> same error response; memory unchanged.
- Reset mid-RMW:
  - Assert reset during the RD cycle of a byte store to 0x84 (word at 0x84 = 0x55555555).
  - Required: next cycle IDLE, req_ready = 1, no mem_write pulse, no rsp_valid, word stays 0x55555555.
- Back-to-back handshake:
  - req_valid held high with two loads queued.
  - Required: second accept occurs in the cycle after DONE; req_ready = 0 during RD and DONE; exactly one rsp_valid pulse per request.
